slt_sltu_serial: RTL and testbench
==================================

SLT_SLTU_SERIAL -- requirements
Module: slt_sltu_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, giving the bits subtracted per cycle; WIDTH SHALL be a multiple of CHUNK.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 I_CLK  input  1  clock; all state SHALL update on the rising edge.
REQ-005 I_RST_N  input  1  asynchronous active-low reset.
REQ-006 I_VALID  input  1  request valid.
REQ-007 O_READY  output  1  block can accept a request.
REQ-008 I_OP_A  input  WIDTH  first operand.
REQ-009 I_OP_B  input  WIDTH  second operand.
REQ-010 I_U  input  1  1 = unsigned compare (SLTU), 0 = signed compare (SLT).
REQ-011 O_VALID  output  1  result valid.
REQ-012 I_READY  input  1  consumer accepts the result.
REQ-013 O_Result  output  1  1 when A < B under the selected mode.
REQ-014 O_EQ  output  1  1 when A == B.

Function
REQ-015 The block SHALL implement a three-state machine with states IDLE, BUSY and DONE.
REQ-016 O_READY SHALL be 1 only in IDLE.
REQ-017 O_VALID SHALL be 1 only in DONE.
REQ-018 On a rising edge where I_VALID=1 in IDLE, the block SHALL: capture I_OP_A, I_OP_B and I_U into internal registers; clear the borrow register and the chunk index; clear the nonzero flag; enter BUSY.
REQ-019 Each BUSY cycle SHALL subtract one CHUNK slice of B from the same slice of A, LSB slice first, using the stored borrow.
REQ-020 In the same BUSY cycle, the block SHALL store the new borrow, OR any nonzero difference bit into the nonzero flag, and increment the index.
REQ-021 After the slice at index WIDTH/CHUNK-1 is processed, the block SHALL enter DONE.
REQ-022 O_VALID SHALL rise exactly WIDTH/CHUNK cycles after the accept edge (8 cycles at the defaults).
REQ-023 The result SHALL be computed as follows.
- I_U=1: result = final borrow.
- I_U=0 and the captured sign bits of A and B differ: result = sign of A.
- I_U=0 and the sign bits are equal: result = final borrow.
REQ-024 O_Result and O_EQ SHALL be registered, and SHALL hold stable while O_VALID=1 and I_READY=0.
REQ-025 In DONE with I_READY=1, the block SHALL return to IDLE on the next edge. Back-to-back accepts are not allowed: the next accept occurs no earlier than the following cycle.
REQ-026 Changes on I_OP_A, I_OP_B, I_U and I_VALID outside IDLE SHALL be ignored.
REQ-027 In IDLE and BUSY, O_Result and O_EQ SHALL keep their last registered values; consumers SHALL qualify them with O_VALID.
REQ-028 WIDTH=CHUNK SHALL be legal and SHALL give a 1-cycle BUSY phase.

Reset
REQ-029 While I_RST_N=0, the block SHALL be in IDLE with O_READY=1, O_VALID=0, O_Result=0 and O_EQ=0, and the borrow, index, nonzero flag and operand registers SHALL be 0.
REQ-030 Reset asserted in BUSY or DONE SHALL abort the operation immediately, with no result produced.
REQ-031 After I_RST_N deasserts, the block SHALL accept a request on the first rising edge.

Configuration
REQ-032 Macro SLT_SLTU_SERIAL_EQ_EN SHALL control equality detection.
- Defined: O_EQ = NOT(nonzero flag), registered on entry to DONE.
- Not defined: the nonzero-flag logic SHALL be absent and O_EQ SHALL be tied to 0.

Verification
REQ-033 Signed negative versus positive: A=0xFFFFFFFF, B=0x00000001, U=0 -> O_Result=1, O_EQ=0, O_VALID rises 8 cycles after accept.
REQ-034 Same operands, unsigned: A=0xFFFFFFFF, B=0x00000001, U=1 -> O_Result=0.
REQ-035 Signed overflow boundary: A=0x80000000, B=0x7FFFFFFF, U=0 -> O_Result=1; same operands with U=1 -> O_Result=0.
REQ-036 Equality: A=B=0x00000005, U=0 -> O_Result=0; O_EQ=1 with the macro defined, O_EQ=0 without it.
REQ-037 Backpressure and ignored inputs: hold I_READY=0 for 3 cycles in DONE -> O_VALID and O_Result stay stable, O_READY=0; operand changes during BUSY do not alter the result.
REQ-038 Reset mid-operation: assert I_RST_N=0 at BUSY index 3 -> next cycle shows the REQ-029 values; a new request A=2, B=3, U=1 then yields O_Result=1.

Source files
------------

// File: rtl/slt_sltu_serial_if.sv
// Request/response bundle for slt_sltu_serial: operands plus the two valid/ready handshakes.
interface slt_sltu_serial_if #(
  parameter int WIDTH = 32
);
  logic             I_VALID;
  logic             O_READY;
  logic [WIDTH-1:0] I_OP_A;
  logic [WIDTH-1:0] I_OP_B;
  logic             I_U;
  logic             O_VALID;
  logic             I_READY;
  logic             O_Result;
  logic             O_EQ;

  modport master (
    output I_VALID, I_OP_A, I_OP_B, I_U, I_READY,
    input  O_READY, O_VALID, O_Result, O_EQ
  );

  modport slave (
    input  I_VALID, I_OP_A, I_OP_B, I_U, I_READY,
    output O_READY, O_VALID, O_Result, O_EQ
  );
endinterface

// File: rtl/slt_sltu_serial.sv
// Serial signed/unsigned less-than: subtracts B from A one CHUNK-bit slice per cycle, LSB first.
// Define SLT_SLTU_SERIAL_EQ_EN to enable the equality output O_EQ (otherwise tied to 0).
module slt_sltu_serial #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input logic              I_CLK,
  input logic              I_RST_N,
  slt_sltu_serial_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             u_q, u_d;
  logic             borrow_q, borrow_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             result_q, result_d;

  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;
  logic             borrow_new;
  logic             last_slice;

  assign a_slice    = op_a_q[int'(idx_q)*CHUNK +: CHUNK];
  assign b_slice    = op_b_q[int'(idx_q)*CHUNK +: CHUNK];
  assign last_slice = (idx_q == LAST_IDX);

  // Borrow-out of a_slice - b_slice - borrow_q, without needing the difference bits.
  assign borrow_new = (a_slice < b_slice) || ((a_slice == b_slice) && borrow_q);

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    u_d      = u_q;
    borrow_d = borrow_q;
    idx_d    = idx_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.I_VALID) begin
          op_a_d   = bus.I_OP_A;
          op_b_d   = bus.I_OP_B;
          u_d      = bus.I_U;
          borrow_d = 1'b0;
          idx_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        borrow_d = borrow_new;
        idx_d    = idx_q + IDX_W'(1);
        if (last_slice) begin
          state_d = DONE;
          // Differing signs decide a signed compare outright; otherwise the unsigned borrow does.
          if (!u_q && (op_a_q[WIDTH-1] != op_b_q[WIDTH-1])) begin
            result_d = op_a_q[WIDTH-1];
          end else begin
            result_d = borrow_new;
          end
        end
      end
      DONE: begin
        if (bus.I_READY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q  <= IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      u_q      <= 1'b0;
      borrow_q <= 1'b0;
      idx_q    <= '0;
      result_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      u_q      <= u_d;
      borrow_q <= borrow_d;
      idx_q    <= idx_d;
      result_q <= result_d;
    end
  end

  assign bus.O_READY  = (state_q == IDLE);
  assign bus.O_VALID  = (state_q == DONE);
  assign bus.O_Result = result_q;

`ifdef SLT_SLTU_SERIAL_EQ_EN
  logic             nz_q, nz_d;
  logic             eq_q, eq_d;
  logic [CHUNK-1:0] diff;

  assign diff = a_slice - b_slice - CHUNK'(borrow_q);

  // The full difference is zero exactly when every slice difference is zero.
  always_comb begin
    nz_d = nz_q;
    eq_d = eq_q;
    if (state_q == IDLE && bus.I_VALID) begin
      nz_d = 1'b0;
    end else if (state_q == BUSY) begin
      nz_d = nz_q | (|diff);
      if (last_slice) begin
        eq_d = ~(nz_q | (|diff));
      end
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      nz_q <= 1'b0;
      eq_q <= 1'b0;
    end else begin
      nz_q <= nz_d;
      eq_q <= eq_d;
    end
  end

  assign bus.O_EQ = eq_q;
`else
  assign bus.O_EQ = 1'b0;
`endif

endmodule

// File: tb/tb_slt_sltu_serial.sv
// Scoreboard bench for slt_sltu_serial: directed vectors, backpressure, mid-operation reset, WIDTH=CHUNK.
`timescale 1ns/1ps
module tb_slt_sltu_serial;
  localparam int WIDTH  = 32;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;
`ifdef SLT_SLTU_SERIAL_EQ_EN
  localparam bit EQ_EN = 1'b1;
`else
  localparam bit EQ_EN = 1'b0;
`endif

  typedef struct {
    logic res;
    logic eq;
    int   acc_cycle;
    int   tag;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  slt_sltu_serial_if #(.WIDTH(WIDTH)) bus ();
  slt_sltu_serial #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .I_CLK   (clk),
    .I_RST_N (rst_n),
    .bus     (bus)
  );

  slt_sltu_serial_if #(.WIDTH(4)) bus_n ();
  slt_sltu_serial #(.WIDTH(4), .CHUNK(4)) dut_n (
    .I_CLK   (clk),
    .I_RST_N (rst_n),
    .bus     (bus_n)
  );

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   cycle      = 0;
  int   tag_id     = 0;
  logic valid_prev = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: latency on each rising O_VALID, result/eq compare on each accepted result.
  always @(negedge clk) begin
    if (bus.O_VALID && !valid_prev) begin
      checkOutput("result_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        checkOutput($sformatf("latency_%0d", sb[0].tag), 32'(cycle - sb[0].acc_cycle), 32'(NCHUNK));
      end
    end
    if (bus.O_VALID && bus.I_READY && sb.size() != 0) begin
      mon_e = sb.pop_front();
      checkOutput($sformatf("result_%0d", mon_e.tag), 32'(bus.O_Result), 32'(mon_e.res));
      checkOutput($sformatf("eq_%0d", mon_e.tag), 32'(bus.O_EQ), 32'(mon_e.eq));
    end
    valid_prev = bus.O_VALID;
  end

  // Called and returns at 1ns after a rising edge; leaves the DUT one cycle into BUSY.
  task automatic doAccept(input logic [31:0] a, input logic [31:0] b, input logic u, output int acc);
    int t;
    t = 0;
    while (!bus.O_READY && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    checkOutput("ready_wait", 32'(bus.O_READY), 32'd1);
    bus.I_OP_A  = a;
    bus.I_OP_B  = b;
    bus.I_U     = u;
    bus.I_VALID = 1'b1;
    @(posedge clk); #1;
    bus.I_VALID = 1'b0;
    acc = cycle;
    checkOutput("busy_not_ready", 32'(bus.O_READY), 32'd0);
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic u,
                               input logic exp_res, input logic eq_if_en);
    exp_t e;
    int   acc;
    doAccept(a, b, u, acc);
    e.res       = exp_res;
    e.eq        = EQ_EN ? eq_if_en : 1'b0;
    e.acc_cycle = acc;
    e.tag       = tag_id;
    tag_id++;
    sb.push_back(e);
  endtask

  task automatic waitDrain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    checkOutput("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int acc;
    bus.I_VALID   = 1'b0;
    bus.I_READY   = 1'b1;
    bus.I_OP_A    = '0;
    bus.I_OP_B    = '0;
    bus.I_U       = 1'b0;
    bus_n.I_VALID = 1'b0;
    bus_n.I_READY = 1'b1;
    bus_n.I_OP_A  = '0;
    bus_n.I_OP_B  = '0;
    bus_n.I_U     = 1'b0;

    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("rst_ready",  32'(bus.O_READY),  32'd1);
    checkOutput("rst_valid",  32'(bus.O_VALID),  32'd0);
    checkOutput("rst_result", 32'(bus.O_Result), 32'd0);
    checkOutput("rst_eq",     32'(bus.O_EQ),     32'd0);
    rst_n = 1'b1;

    // Directed vectors: a, b, u, expected result, expected eq when enabled.
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h0000_0005, 32'h0000_0005, 1'b0, 1'b0, 1'b1);
    applyStimulus(32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, 1'b1);
    applyStimulus(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h1234_5678, 32'h1234_5679, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    waitDrain();

    // Backpressure with junk on the request side while BUSY and DONE.
    bus.I_READY = 1'b0;
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
    bus.I_OP_A  = 32'h0000_0000;
    bus.I_OP_B  = 32'h0000_0000;
    bus.I_U     = 1'b1;
    bus.I_VALID = 1'b1;
    begin
      int t;
      t = 0;
      while (!bus.O_VALID && t < 100) begin
        @(posedge clk); #1;
        t++;
      end
    end
    checkOutput("bp_valid_seen", 32'(bus.O_VALID), 32'd1);
    bus.I_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("bp_valid_%0d", i),  32'(bus.O_VALID),  32'd1);
      checkOutput($sformatf("bp_result_%0d", i), 32'(bus.O_Result), 32'd1);
      checkOutput($sformatf("bp_eq_%0d", i),     32'(bus.O_EQ),     32'd0);
      checkOutput($sformatf("bp_ready_%0d", i),  32'(bus.O_READY),  32'd0);
      @(posedge clk); #1;
    end
    bus.I_READY = 1'b1;
    waitDrain();

    // Abort at BUSY index 3; the previous result was 1, so reset must clear it.
    doAccept(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, acc);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_ready",  32'(bus.O_READY),  32'd1);
    checkOutput("abort_valid",  32'(bus.O_VALID),  32'd0);
    checkOutput("abort_result", 32'(bus.O_Result), 32'd0);
    checkOutput("abort_eq",     32'(bus.O_EQ),     32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(32'h0000_0002, 32'h0000_0003, 1'b1, 1'b1, 1'b0);
    waitDrain();

    // WIDTH == CHUNK instance: one BUSY cycle.
    bus_n.I_OP_A  = 4'h8;
    bus_n.I_OP_B  = 4'h1;
    bus_n.I_U     = 1'b0;
    bus_n.I_VALID = 1'b1;
    @(posedge clk); #1;
    bus_n.I_VALID = 1'b0;
    checkOutput("n_busy_valid", 32'(bus_n.O_VALID), 32'd0);
    checkOutput("n_busy_ready", 32'(bus_n.O_READY), 32'd0);
    @(posedge clk); #1;
    checkOutput("n_done_valid",  32'(bus_n.O_VALID),  32'd1);
    checkOutput("n_done_result", 32'(bus_n.O_Result), 32'd1);
    checkOutput("n_done_eq",     32'(bus_n.O_EQ),     32'd0);
    @(posedge clk); #1;
    checkOutput("n_idle_ready", 32'(bus_n.O_READY), 32'd1);
    bus_n.I_OP_A  = 4'h3;
    bus_n.I_OP_B  = 4'h3;
    bus_n.I_U     = 1'b1;
    bus_n.I_VALID = 1'b1;
    @(posedge clk); #1;
    bus_n.I_VALID = 1'b0;
    @(posedge clk); #1;
    checkOutput("n_eq_valid",  32'(bus_n.O_VALID),  32'd1);
    checkOutput("n_eq_result", 32'(bus_n.O_Result), 32'd0);
    checkOutput("n_eq_eq",     32'(bus_n.O_EQ),     32'(EQ_EN));

    repeat (2) begin
      @(posedge clk); #1;
    end
    checkOutput("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
